// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU CPU-facing register block: register
// indices as decoded from CPU addr[2:0] and the read-buffer fetch states.
package ppu_pkg;

  localparam logic [2:0] CTRL    = 3'd0;
  localparam logic [2:0] MASK    = 3'd1;
  localparam logic [2:0] STATUS  = 3'd2;
  localparam logic [2:0] OAMADDR = 3'd3;
  localparam logic [2:0] OAMDATA = 3'd4;
  localparam logic [2:0] SCROLL  = 3'd5;
  localparam logic [2:0] ADDR    = 3'd6;
  localparam logic [2:0] DATA    = 3'd7;

  // Read buffer is idle, or waiting for the VRAM data requested last cycle.
  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  localparam logic [13:0] VRAM_STEP_ROW = 14'd32;
  localparam logic [13:0] VRAM_STEP_COL = 14'd1;

endpackage

// File: rtl/ppu_regs.sv
// CPU-visible PPU register file ($2000-$2007, mirrored through $3FFF).
// Memory strobes (oam_we, vram_we, vram_re) are combinational with the
// access cycle so the external memories see the pre-increment address on
// the same edge where the pointer advances. VRAM read data arrives one
// cycle after vram_re and is captured into the read buffer while in FETCH.
// Handshake: cs is a one-cycle strobe, there is no back-pressure; every
// cs=1 cycle is exactly one access and cs=0 cycles change nothing.
module ppu_regs
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  reg_sel,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic [7:0]  ctrl,
  output logic [7:0]  mask,
  output logic [7:0]  scroll_x,
  output logic [7:0]  scroll_y,
  output logic [7:0]  oam_addr,
  output logic        oam_we,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata,
  output logic [13:0] vram_addr,
  output logic        vram_we,
  output logic        vram_re,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  input  logic        vblank_start,
  input  logic        vblank_end,
  output logic        nmi
);

  fetch_state_e state_q, state_d;
  logic         vblank_flag;
  logic         vblank_d;
  logic         w_q;
  logic [7:0]   rd_buf;
  logic [7:0]   rd_data;
  logic [7:0]   ctrl_d;
  logic [13:0]  vram_step;
  logic         wr_acc;
  logic         rd_acc;
  logic         status_rd;

  assign wr_acc    = cs & we;
  assign rd_acc    = cs & ~we;
  assign status_rd = rd_acc && (reg_sel == STATUS);
  assign vram_step = ctrl[2] ? VRAM_STEP_ROW : VRAM_STEP_COL;

  // Strobes follow the access cycle and are forced low during reset.
  assign oam_we     = ~rst & wr_acc & (reg_sel == OAMDATA);
  assign vram_we    = ~rst & wr_acc & (reg_sel == DATA);
  assign vram_re    = ~rst & rd_acc & (reg_sel == DATA);
  assign oam_wdata  = oam_we  ? d_in : 8'h00;
  assign vram_wdata = vram_we ? d_in : 8'h00;

  // Read mux; a STATUS read racing vblank_start reports the flag as clear.
  always_comb begin
    rd_data = 8'h00;
    case (reg_sel)
      STATUS:  rd_data = vblank_start ? 8'h00 : {vblank_flag, 7'b0};
      OAMDATA: rd_data = oam_rdata;
      DATA:    rd_data = rd_buf;
      default: rd_data = 8'h00;
    endcase
  end

  // Next values of the NMI inputs so nmi tracks them one cycle later.
  always_comb begin
    vblank_d = vblank_flag;
    if (vblank_start)                 vblank_d = 1'b1;
    else if (vblank_end || status_rd) vblank_d = 1'b0;
    ctrl_d = (wr_acc && reg_sel == CTRL) ? d_in : ctrl;
  end

  // Fetch FSM next state: a DATA read starts a fetch that lasts one cycle.
  always_comb begin
    state_d = IDLE;
    if (rd_acc && reg_sel == DATA) state_d = FETCH;
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Read buffer captures VRAM data on the edge that leaves FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  rd_buf <= 8'h00;
    else if (state_q == FETCH) rd_buf <= vram_rdata;
  end

  // Control, mask, scroll and the shared write toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl     <= 8'h00;
      mask     <= 8'h00;
      scroll_x <= 8'h00;
      scroll_y <= 8'h00;
      w_q      <= 1'b0;
    end else begin
      ctrl <= ctrl_d;
      if (wr_acc && reg_sel == MASK) mask <= d_in;
      if (wr_acc && reg_sel == SCROLL) begin
        if (w_q) scroll_y <= d_in;
        else     scroll_x <= d_in;
      end
      if (status_rd)
        w_q <= 1'b0;
      else if (wr_acc && (reg_sel == SCROLL || reg_sel == ADDR))
        w_q <= ~w_q;
    end
  end

  // OAM and VRAM address pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oam_addr  <= 8'h00;
      vram_addr <= 14'h0000;
    end else begin
      if (wr_acc && reg_sel == OAMADDR)
        oam_addr <= d_in;
      else if (wr_acc && reg_sel == OAMDATA)
        oam_addr <= oam_addr + 8'd1;
      if (wr_acc && reg_sel == ADDR) begin
        if (w_q) vram_addr <= {vram_addr[13:8], d_in};
        else     vram_addr <= {d_in[5:0], vram_addr[7:0]};
      end else if (cs && reg_sel == DATA) begin
        vram_addr <= vram_addr + vram_step;
      end
    end
  end

  // Read data, vblank flag and registered NMI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out       <= 8'h00;
      vblank_flag <= 1'b0;
      nmi         <= 1'b0;
    end else begin
      if (rd_acc) d_out <= rd_data;
      vblank_flag <= vblank_d;
      nmi         <= vblank_d & ctrl_d[7];
    end
  end

endmodule

// File: doc/ppu_regs.md
PPU_REGS -- requirements
Module: ppu_regs

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): none; all widths are fixed by the NES PPU register map.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cs  in  1  one-cycle access strobe, decoded externally from CPU addr $2000-$3FFF
- we  in  1  1 = CPU write, 0 = CPU read; sampled with cs
- reg_sel  in  3  CPU addr[2:0]; register index 0-7
- d_in  in  8  CPU write data
- d_out  out  8  registered CPU read data
- ctrl  out  8  PPUCTRL ($2000)
- mask  out  8  PPUMASK ($2001)
- scroll_x  out  8  first $2005 write
- scroll_y  out  8  second $2005 write
- oam_addr  out  8  OAM address
- oam_we  out  1  one-cycle OAM write strobe
- oam_wdata  out  8  OAM write data
- oam_rdata  in  8  OAM data at oam_addr, combinational
- vram_addr  out  14  VRAM address pointer
- vram_we  out  1  one-cycle VRAM write strobe
- vram_re  out  1  one-cycle VRAM read strobe
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  VRAM read data, valid exactly 1 cycle after vram_re
- vblank_start  in  1  one-cycle pulse from PPU timing
- vblank_end  in  1  one-cycle pulse from PPU timing
- nmi  out  1  NMI request to CPU, level, active-high

Function
REQ-003 An access SHALL occur on each rising edge with cs=1; cs=0 cycles SHALL have no side effects.
REQ-004 Read data SHALL appear on d_out one cycle after the access and SHALL hold until the next read.
REQ-005 Writes to reg 0, 1, and 3 SHALL load ctrl, mask, and oam_addr respectively; reads of reg 0, 1, 3, 5, and 6 SHALL return 8'h00.
REQ-006 A reg 2 (STATUS) read SHALL return {vblank_flag, 7'b0}, clear vblank_flag, and clear the write toggle w.
REQ-007 A reg 4 write SHALL pulse oam_we for one cycle with oam_wdata=d_in at the current oam_addr, then increment oam_addr modulo 256 (8'hFF -> 8'h00).
REQ-008 A reg 4 read SHALL return oam_rdata and SHALL NOT increment oam_addr.
REQ-009 A reg 5 write SHALL load scroll_x when w=0 and scroll_y when w=1, then toggle w.
REQ-010 A reg 6 write with w=0 SHALL set vram_addr[13:8]=d_in[5:0]; with w=1 it SHALL set vram_addr[7:0]=d_in; each write SHALL then toggle w.
REQ-011 A reg 7 write SHALL pulse vram_we for one cycle with the pre-increment vram_addr and vram_wdata=d_in.
REQ-012 A reg 7 read SHALL return the current read buffer, pulse vram_re with the pre-increment vram_addr, and enter FETCH.
REQ-013 Read-buffer FSM: IDLE -> FETCH on a reg 7 read; FETCH -> IDLE on the next cycle, loading the buffer from vram_rdata.
REQ-014 A reg 7 access arriving in FETCH SHALL be performed normally, with buffer capture taking effect on the same edge.
REQ-015 Every reg 7 access SHALL increment vram_addr by 32 when ctrl[2]=1, else by 1, modulo 2^14.
REQ-016 There SHALL be no palette special case in this block.
REQ-017 vblank_flag SHALL be set by vblank_start and cleared by vblank_end or a STATUS read.
REQ-018 If vblank_start coincides with a STATUS read, the read SHALL return bit7=0 and the flag SHALL end up set.
REQ-019 nmi SHALL equal vblank_flag & ctrl[7], driven from registers.
REQ-020 Setting ctrl[7] while vblank_flag=1 SHALL raise nmi on the next cycle.
REQ-021 Register index 7 accesses SHALL be mirrored across the whole $2000-$3FFF range, since only reg_sel is decoded.

Reset
REQ-022 rst SHALL asynchronously clear all outputs, vblank_flag, w, and the read buffer to zero.
REQ-023 rst SHALL return the FSM to IDLE.
REQ-024 rst SHALL abandon an in-flight FETCH without updating the buffer.
REQ-025 Strobes SHALL be low while rst=1.

Structure
REQ-026 Package ppu_pkg SHALL hold the register-index constants (CTRL=0 ... DATA=7) and the fetch-state enum {IDLE, FETCH}.
REQ-027 The block SHALL be a single module with no sub-modules.

Verification
REQ-028 Write reg 6 = 8'h21, then 8'h08 -> vram_addr=14'h2108 and w=0.
REQ-029 Continuing REQ-028, write reg 7 = 8'hAB -> vram_we pulses at 14'h2108, then vram_addr=14'h2109.
REQ-030 ctrl=8'h04, vram_addr=14'h0000, rdata model holds 8'h11, 8'h22 at addresses 0 and 32; issue two reg 7 reads -> d_out returns the old buffer, then 8'h11; vram_addr=14'h0040.
REQ-031 Pulse vblank_start with ctrl=8'h80 -> nmi=1; STATUS read -> d_out=8'h80, then nmi=0.
REQ-032 STATUS read coincident with vblank_start -> d_out=8'h00 and the flag remains set.
REQ-033 Set oam_addr=8'hFF, write reg 4 = 8'h5A -> oam_we pulse at 8'hFF, then oam_addr=8'h00.
REQ-034 Write reg 6 once (w=1), then STATUS read, then write reg 5 = 8'h10 -> scroll_x=8'h10.
